// File: rtl/bht_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bht_pkg
// Description : Shared types and constants for the branch history table.
// Revision    : 1.0 - initial release
// ============================================================================
package bht_pkg;

  localparam int c_INDEX_BITS_DEF = 6;
  localparam int c_TAG_BITS_DEF   = 8;
  // Widest tag any legal parameter set can need (32-bit PC minus byte offset).
  localparam int c_TAG_MAX        = 30;

  typedef logic [1:0] ctr_t;

  localparam ctr_t c_SNT = 2'b00;
  localparam ctr_t c_WNT = 2'b01;
  localparam ctr_t c_WT  = 2'b10;
  localparam ctr_t c_ST  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [c_TAG_MAX-1:0] tag;
    ctr_t                 ctr;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/bht_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : bht_sat_counter
// Description : Next-state logic of a 2-bit saturating branch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_sat_counter
  import bht_pkg::*;
(
  input  ctr_t curCtr,
  input  logic taken,
  output ctr_t nextCtr
);

  always_comb begin
    nextCtr = curCtr;
    if (taken && (curCtr != c_ST)) begin
      nextCtr = curCtr + 2'd1;
    end else if (!taken && (curCtr != c_SNT)) begin
      nextCtr = curCtr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_table
// Description : Tagged 2-bit-counter branch predictor with F->D->E carry of
//               prediction/index/tag. Optional BHT_STATS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table
  import bht_pkg::*;
#(
  parameter int INDEX_BITS = c_INDEX_BITS_DEF,
  parameter int TAG_BITS   = c_TAG_BITS_DEF
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic        IsBranchE,
  input  logic        BranchE,
  output logic        PredTakenF,
`ifdef BHT_STATS_EN
  output logic [31:0] BrCount,
  output logic [31:0] MissCount,
`endif
  output logic        isBhtTakenE
);

  localparam int c_DEPTH = 1 << INDEX_BITS;

  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [c_TAG_MAX-1:0]  tag_t;

  entry_t r_table [c_DEPTH];

  idx_t   w_idxF;
  tag_t   w_tagF;
  logic   w_predF;
  logic   w_unusedPc;

  logic   r_predD;
  idx_t   r_idxD;
  tag_t   r_tagD;
  logic   r_predE;
  idx_t   r_idxE;
  tag_t   r_tagE;

  entry_t w_updEntry;
  logic   w_updEn;
  logic   w_updHit;
  ctr_t   w_nextCtr;

  assign w_idxF     = PCF[INDEX_BITS+1:2];
  assign w_tagF     = tag_t'(PCF[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]);
  assign w_unusedPc = ^PCF;

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign w_predF = r_table[w_idxF].valid
                && (r_table[w_idxF].tag == w_tagF)
                && r_table[w_idxF].ctr[1];

  assign PredTakenF  = w_predF;
  assign isBhtTakenE = r_predE;

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      r_predD <= 1'b0;
      r_idxD  <= '0;
      r_tagD  <= '0;
      r_predE <= 1'b0;
      r_idxE  <= '0;
      r_tagE  <= '0;
    end else begin
      if (FlushD) begin
        r_predD <= 1'b0;
        r_idxD  <= '0;
        r_tagD  <= '0;
      end else if (!StallD) begin
        r_predD <= w_predF;
        r_idxD  <= w_idxF;
        r_tagD  <= w_tagF;
      end
      if (FlushE) begin
        r_predE <= 1'b0;
        r_idxE  <= '0;
        r_tagE  <= '0;
      end else if (!StallE) begin
        r_predE <= r_predD;
        r_idxE  <= r_idxD;
        r_tagE  <= r_tagD;
      end
    end
  end

  // Update uses the index/tag captured at fetch time, not the current PCF.
  assign w_updEntry = r_table[r_idxE];
  assign w_updEn    = IsBranchE && !StallE;
  assign w_updHit   = w_updEntry.valid && (w_updEntry.tag == r_tagE);

  bht_sat_counter u_satCtr (
    .curCtr  (w_updEntry.ctr),
    .taken   (BranchE),
    .nextCtr (w_nextCtr)
  );

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_updEn) begin
      if (w_updHit) begin
        r_table[r_idxE].ctr <= w_nextCtr;
      end else if (BranchE) begin
        r_table[r_idxE] <= '{valid: 1'b1, tag: r_tagE, ctr: c_WT};
      end
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] r_brCount;
  logic [31:0] r_missCount;

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      r_brCount   <= '0;
      r_missCount <= '0;
    end else if (w_updEn) begin
      r_brCount <= r_brCount + 32'd1;
      if (BranchE != r_predE) begin
        r_missCount <= r_missCount + 32'd1;
      end
    end
  end

  assign BrCount   = r_brCount;
  assign MissCount = r_missCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_history_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_history_table
// Description : Self-checking bench for branch_history_table against a
//               behavioural table/pipeline model, directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_history_table;

  localparam logic [31:0] c_IDLE_PC = 32'h0000_FFFC;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic [31:0] PCF = '0;
  logic        StallD = 1'b0, FlushD = 1'b0, StallE = 1'b0, FlushE = 1'b0;
  logic        IsBranchE = 1'b0, BranchE = 1'b0;
  logic        PredTakenF, isBhtTakenE;
`ifdef BHT_STATS_EN
  logic [31:0] BrCount, MissCount;
`endif

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  branch_history_table dut (
    .CPU_CLK     (clk),
    .CPU_RST_N   (rstN),
    .PCF         (PCF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .IsBranchE   (IsBranchE),
    .BranchE     (BranchE),
    .PredTakenF  (PredTakenF),
`ifdef BHT_STATS_EN
    .BrCount     (BrCount),
    .MissCount   (MissCount),
`endif
    .isBhtTakenE (isBhtTakenE)
  );

  // Behavioural model: 64 entries, tag = PC[15:8], counter as 0..3 integer.
  bit          mValid [64];
  int          mTag   [64];
  int          mCtr   [64];
  bit          mPD = 0, mPE = 0;
  int          mID = 0, mTD = 0, mIE = 0, mTE = 0;
  int unsigned mBr = 0, mMiss = 0;

  function automatic int pcIdx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63);
  endfunction

  function automatic int pcTag(input logic [31:0] pc);
    return int'((pc >> 8) & 32'd255);
  endfunction

  function automatic bit modelPred(input logic [31:0] pc);
    int i = pcIdx(pc);
    return mValid[i] && (mTag[i] == pcTag(pc)) && (mCtr[i] >= 2);
  endfunction

  bit fPred;
  int ui;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 64; i++) begin
        mValid[i] = 0; mTag[i] = 0; mCtr[i] = 0;
      end
      mPD = 0; mID = 0; mTD = 0; mPE = 0; mIE = 0; mTE = 0;
      mBr = 0; mMiss = 0;
    end else begin
      fPred = modelPred(PCF);
      if (IsBranchE && !StallE) begin
        ui = mIE;
        mBr++;
        if (BranchE != mPE) mMiss++;
        if (mValid[ui] && mTag[ui] == mTE) begin
          if (BranchE) mCtr[ui] = (mCtr[ui] == 3) ? 3 : mCtr[ui] + 1;
          else         mCtr[ui] = (mCtr[ui] == 0) ? 0 : mCtr[ui] - 1;
        end else if (BranchE) begin
          mValid[ui] = 1; mTag[ui] = mTE; mCtr[ui] = 2;
        end
      end
      if (FlushE) begin
        mPE = 0; mIE = 0; mTE = 0;
      end else if (!StallE) begin
        mPE = mPD; mIE = mID; mTE = mTD;
      end
      if (FlushD) begin
        mPD = 0; mID = 0; mTD = 0;
      end else if (!StallD) begin
        mPD = fPred; mID = pcIdx(PCF); mTD = pcTag(PCF);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("PredTakenF_vs_model", {31'd0, PredTakenF}, {31'd0, modelPred(PCF)});
    chk("isBhtTakenE_vs_model", {31'd0, isBhtTakenE}, {31'd0, mPE});
`ifdef BHT_STATS_EN
    chk("BrCount_vs_model", BrCount, mBr);
    chk("MissCount_vs_model", MissCount, mMiss);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
  endtask

  // Fetch pc, let it reach E, then resolve it there.
  task automatic runBranch(input logic [31:0] pc, input logic taken);
    PCF = pc; IsBranchE = 1'b0; tick();
    PCF = c_IDLE_PC; tick();
    IsBranchE = 1'b1; BranchE = taken; tick();
    IsBranchE = 1'b0; BranchE = 1'b0;
  endtask

  task automatic expectPred(input string name, input logic [31:0] pc, input logic exp);
    PCF = pc;
    #1;
    chk(name, {31'd0, PredTakenF}, {31'd0, exp});
  endtask

  initial begin
    int expCtr [6] = '{3, 3, 3, 3, 2, 1};
    bit seqTk  [6] = '{1, 1, 1, 1, 0, 0};

    #2 rstN = 1'b0;
    tick();
    chk("reset_isBhtTakenE", {31'd0, isBhtTakenE}, 32'd0);
    rstN = 1'b1;

    for (int i = 0; i < 64; i++) begin
      expectPred("sweep_pred_zero", 32'(i * 4), 1'b0);
      tick();
    end
    chk("sweep_isBhtTakenE", {31'd0, isBhtTakenE}, 32'd0);

    runBranch(32'h40, 1'b1);
    chk("model_ctr_alloc", mCtr[16], 32'd2);
    expectPred("pred_after_alloc", 32'h40, 1'b1);

    for (int k = 0; k < 6; k++) begin
      runBranch(32'h40, seqTk[k]);
      chk("model_ctr_seq", mCtr[16], expCtr[k]);
      expectPred("pred_ctr_seq", 32'h40, (expCtr[k] >= 2) ? 1'b1 : 1'b0);
    end

    doReset();
    runBranch(32'h40, 1'b1);
    runBranch(32'h4040, 1'b1);
    expectPred("alias_old_tag", 32'h40, 1'b0);
    expectPred("alias_new_tag", 32'h4040, 1'b1);
    runBranch(32'h8040, 1'b0);
    expectPred("nt_miss_keeps", 32'h4040, 1'b1);
    expectPred("nt_miss_noalloc", 32'h8040, 1'b0);
    chk("model_tag_kept", mTag[16], 32'h40);

    // Stalled not-taken must decrement once only: 10 -> 01, then taken -> 10.
    runBranch(32'h80, 1'b1);
    PCF = 32'h80; tick();
    PCF = c_IDLE_PC; tick();
    IsBranchE = 1'b1; BranchE = 1'b0; StallE = 1'b1; StallD = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("stall_holds_pred", {31'd0, isBhtTakenE}, 32'd1);
    StallE = 1'b0; StallD = 1'b0; tick();
    IsBranchE = 1'b0;
    chk("model_ctr_stall", mCtr[32], 32'd1);
    expectPred("pred_after_stall_nt", 32'h80, 1'b0);
    runBranch(32'h80, 1'b1);
    expectPred("pred_single_update", 32'h80, 1'b1);

    PCF = 32'h80; tick();
    PCF = c_IDLE_PC; tick();
    chk("latency_two_edges", {31'd0, isBhtTakenE}, 32'd1);
    StallE = 1'b1; FlushE = 1'b1; tick();
    chk("flush_over_stall", {31'd0, isBhtTakenE}, 32'd0);
    StallE = 1'b0; FlushE = 1'b0;

    doReset();
    for (int k = 0; k < 10; k++) runBranch(32'h100, (k < 8) ? 1'b1 : 1'b0);
`ifdef BHT_STATS_EN
    chk("stats_brcount", BrCount, 32'd10);
    chk("stats_misscount", MissCount, 32'd3);
`endif
    chk("model_miss_pin", mMiss, 32'd3);
    runBranch(32'h80, 1'b1);
    PCF = 32'h80; tick();
    PCF = c_IDLE_PC; tick();
    chk("pre_async_reset_pred", {31'd0, isBhtTakenE}, 32'd1);
    PCF = 32'h80;
    #2 rstN = 1'b0;
    #1;
    chk("async_reset_isBhtTakenE", {31'd0, isBhtTakenE}, 32'd0);
    chk("async_reset_predF", {31'd0, PredTakenF}, 32'd0);
`ifdef BHT_STATS_EN
    chk("async_reset_brcount", BrCount, 32'd0);
    chk("async_reset_misscount", MissCount, 32'd0);
`endif
    tick();
    rstN = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      PCF       = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      IsBranchE = 1'($urandom_range(0, 1));
      BranchE   = 1'($urandom_range(0, 1));
      StallD    = ($urandom_range(0, 9) == 0);
      StallE    = ($urandom_range(0, 9) == 0);
      FlushD    = ($urandom_range(0, 19) == 0);
      FlushE    = ($urandom_range(0, 19) == 0);
      tick();
      if (c == 1500) begin
        #2 rstN = 1'b0;
        #3 rstN = 1'b1;
      end
    end
    IsBranchE = 1'b0; StallD = 1'b0; StallE = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, selecting the table depth (2^INDEX_BITS entries).
REQ-002 SHALL have parameter TAG_BITS, default 8, giving the tag width stored per entry.
REQ-003 SHALL have port CPU_CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port CPU_RST_N  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port PCF  in  32  fetch-stage PC.
REQ-006 SHALL have ports StallD, FlushD, StallE, FlushE  in  1 each  pipeline controls from the hazard unit.
REQ-007 SHALL have port IsBranchE  in  1  E-stage instruction is a conditional branch.
REQ-008 SHALL have port BranchE  in  1  resolved branch outcome in E (1 = taken).
REQ-009 SHALL have port PredTakenF  out  1  combinational fetch-stage prediction.
REQ-010 SHALL have port isBhtTakenE  out  1  registered prediction aligned with the E-stage instruction.

Function
REQ-011 SHALL derive index = PC[INDEX_BITS+1:2] and tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
REQ-012 SHALL hold per entry: valid bit, TAG_BITS tag, 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-013 SHALL drive PredTakenF = 1 only when the PCF entry is valid, its tag matches, and counter[1] = 1; otherwise 0.
REQ-014 SHALL carry the prediction F->D->E and carry the F index/tag alongside it, so the E-stage update uses the fetch-time index/tag.
REQ-015 SHALL clear a stage register (prediction, index, tag) to 0 on its Flush; Flush SHALL take priority over Stall.
REQ-016 SHALL hold a stage register on its Stall; the F->D register follows StallD/FlushD and the D->E register follows StallE/FlushE.
REQ-017 SHALL perform an update event when IsBranchE = 1 and StallE = 0, at most once per E-stage instruction.
REQ-018 On an update hit (valid and tag match), the counter SHALL increment saturating at 11 if BranchE = 1, and decrement saturating at 00 if BranchE = 0.
REQ-019 On an update miss with BranchE = 1, the entry SHALL be allocated with valid = 1, the new tag, and counter = 10, replacing any occupant.
REQ-020 On an update miss with BranchE = 0, the table SHALL be left unchanged.
REQ-021 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update value (no bypass).
REQ-022 Prediction latency: PredTakenF SHALL be combinational from PCF, and isBhtTakenE SHALL appear two unstalled edges later.

Reset
REQ-023 On CPU_RST_N = 0, all valid bits SHALL clear, all stage registers SHALL clear, and isBhtTakenE SHALL be 0, asynchronously; PredTakenF SHALL then be 0 for every PCF.
REQ-024 Reset asserted mid-operation SHALL abort any pending update; no table write SHALL occur while reset is asserted.

Configuration
REQ-025 With macro BHT_STATS_EN defined, the block SHALL add output ports BrCount (32) and MissCount (32), both reset to 0.
REQ-026 Under BHT_STATS_EN, BrCount SHALL increment on each update event, and MissCount SHALL increment on each update event where BranchE != isBhtTakenE; both SHALL wrap modulo 2^32.
REQ-027 Without BHT_STATS_EN, those ports and their counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-028 Package bht_pkg SHALL hold the counter encodings (SNT/WNT/WT/ST), the INDEX_BITS/TAG_BITS defaults, and the entry struct typedef.
REQ-029 Sub-module bht_sat_counter SHALL compute the next counter value from (current, taken) and SHALL be the only place saturation logic lives.

Verification
REQ-030 Reset, then sweep PCF over 0x0000_0000..0x0000_00FC -> PredTakenF = 0 everywhere; isBhtTakenE = 0.
REQ-031 Taken branch at PC 0x0000_0040 (IsBranchE = 1, BranchE = 1) -> next fetch of 0x40 gives PredTakenF = 1 (counter 10).
REQ-032 Four further taken updates, then two not-taken updates at 0x40 -> counter sequence 11, 11, 11, 11, 10, 01; PredTakenF = 0 after the second not-taken.
REQ-033 Taken at 0x40, then taken at 0x0000_4040 (same index, different tag) -> 0x40 predicts 0 and 0x4040 predicts 1; a not-taken miss at 0x8040 leaves 0x4040 unchanged.
REQ-034 StallE = 1 for 3 cycles with IsBranchE = 1 -> exactly one counter update; FlushE together with StallE -> isBhtTakenE = 0.
REQ-035 With BHT_STATS_EN, run 10 updates with 3 mispredictions -> BrCount = 10, MissCount = 3; asserting CPU_RST_N low mid-run -> both counts read 0 immediately.
